// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg
//   Shared constants and types for the Pong score keeper.
//   - state_t      : game-flow FSM encoding (also exported for debug)
//   - WIN_*        : winner codes shown on the winner output
//   - SERVE_*      : serve direction codes
//   - score_inc    : saturating BCD-digit increment (never passes 9)
package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_PAUSE     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam logic [3:0] SCORE_MAX = 4'd9;

    // The match ends at the win score (<= 9), so this saturation never
    // triggers in normal play; it keeps the digit a legal BCD value anyway.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if
//   Bundle between the ball/button logic (master) and the score keeper (slave).
//   Ports:
//     start     master->slave  1-cycle pulse, start/restart the match
//     miss_p1   master->slave  1-cycle pulse, ball passed the left paddle
//     miss_p2   master->slave  1-cycle pulse, ball passed the right paddle
//     score_p1  slave->master  BCD score, player 1
//     score_p2  slave->master  BCD score, player 2
//     play      slave->master  1 = ball may move
//     serve_dir slave->master  0 = serve left (P1), 1 = serve right (P2)
//     game_over slave->master  1 while the match is over
//     winner    slave->master  00 none, 01 P1, 10 P2
//   Handshake: there is no valid/ready pair. Every master->slave signal is a
//   single-cycle event pulse sampled on the rising clock edge and is never
//   back-pressured; the slave either acts on it that edge or drops it. All
//   slave->master signals are registered levels.
interface score_keeper_if;
    import score_keeper_pkg::*;

    logic       start;
    logic       miss_p1;
    logic       miss_p2;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       play;
    logic       serve_dir;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, miss_p1, miss_p2,
        input  score_p1, score_p2, play, serve_dir, game_over, winner
    );

    modport slave (
        input  start, miss_p1, miss_p2,
        output score_p1, score_p2, play, serve_dir, game_over, winner
    );

endinterface

// File: rtl/score_keeper_pause_timer.sv
// score_keeper_pause_timer
//   Down-counter that times the ball freeze after a point.
//   Ports:
//     clk   in  clock
//     rst_n in  asynchronous active-low reset (counter -> 0)
//     load  in  reload with p_PAUSE_CYCLES-1 (has priority over en)
//     en    in  count down by one while non-zero
//     done  out counter has reached zero
//   Loaded on the edge that enters the pause; with p_PAUSE_CYCLES-1 loaded
//   and the FSM leaving on the edge that sees done, the freeze lasts exactly
//   p_PAUSE_CYCLES clocks. The counter holds at zero rather than wrapping.
module score_keeper_pause_timer #(
    parameter int p_PAUSE_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(p_PAUSE_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(p_PAUSE_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/score_keeper.sv
// score_keeper
//   Match-level score and game-flow controller for Pong. Counts points from
//   the ball logic's miss pulses, gates ball motion (pause after each point,
//   then serve) and declares the winner at p_WIN_SCORE.
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset, synchronous release
//     sk        slave modport of score_keeper_if (pulses in, scores/flags out)
//     dbg_state out  current FSM state
//   All interface outputs are registered: an input sampled at edge N shows
//   its effect right after edge N.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int p_WIN_SCORE    = 9,
    parameter int p_PAUSE_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    score_keeper_if.slave        sk,
    output state_t               dbg_state
);

    localparam logic [3:0] WIN_SCORE = 4'(p_WIN_SCORE);

    state_t     state_q, state_d;
    logic [3:0] score_p1_q, score_p1_d;
    logic [3:0] score_p2_q, score_p2_d;
    logic       serve_q, serve_d;
    logic [1:0] winner_q, winner_d;
    logic       play_q, play_d;
    logic       game_over_q, game_over_d;

    logic       timer_load;
    logic       timer_done;
    logic [3:0] score_inc_p1;
    logic [3:0] score_inc_p2;

    score_keeper_pause_timer #(
        .p_PAUSE_CYCLES(p_PAUSE_CYCLES)
    ) u_pause_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (state_q == ST_PAUSE),
        .done  (timer_done)
    );

    assign score_inc_p1 = score_inc(score_p1_q);
    assign score_inc_p2 = score_inc(score_p2_q);

    // State and match registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            score_p1_q <= '0;
            score_p2_q <= '0;
            serve_q    <= SERVE_LEFT;
            winner_q   <= WIN_NONE;
        end else begin
            state_q    <= state_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            serve_q    <= serve_d;
            winner_q   <= winner_d;
        end
    end

    // Next-state and score update.
    always_comb begin
        state_d    = state_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        serve_d    = serve_q;
        winner_d   = winner_q;
        timer_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sk.start) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                    state_d    = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (sk.miss_p1 && sk.miss_p2) begin
                    // Simultaneous miss: nobody scores, serve swaps sides.
                    serve_d    = ~serve_q;
                    timer_load = 1'b1;
                    state_d    = ST_PAUSE;
                end else if (sk.miss_p1) begin
                    // Ball got past P1: point to P2, next serve toward P1.
                    score_p2_d = score_inc_p2;
                    serve_d    = SERVE_LEFT;
                    if (score_inc_p2 == WIN_SCORE) begin
                        winner_d = WIN_P2;
                        state_d  = ST_GAME_OVER;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = ST_PAUSE;
                    end
                end else if (sk.miss_p2) begin
                    score_p1_d = score_inc_p1;
                    serve_d    = SERVE_RIGHT;
                    if (score_inc_p1 == WIN_SCORE) begin
                        winner_d = WIN_P1;
                        state_d  = ST_GAME_OVER;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = ST_PAUSE;
                    end
                end
            end

            ST_PAUSE: begin
                if (timer_done) begin
                    state_d = ST_PLAY;
                end
            end

            ST_GAME_OVER: begin
                // Restart keeps the last serve direction.
                if (sk.start) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                    winner_d   = WIN_NONE;
                    state_d    = ST_PLAY;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode, taken from the next state so the registered flags
    // change on the same edge as the state itself.
    always_comb begin
        play_d      = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            play_q      <= play_d;
            game_over_q <= game_over_d;
        end
    end

    assign sk.score_p1  = score_p1_q;
    assign sk.score_p2  = score_p2_q;
    assign sk.play      = play_q;
    assign sk.serve_dir = serve_q;
    assign sk.game_over = game_over_q;
    assign sk.winner    = winner_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;
    import score_keeper_pkg::*;

    localparam int WIN   = 3;
    localparam int PAUSE = 4;
    localparam int EW    = 15;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    score_keeper_if sk_if ();

    score_keeper #(
        .p_WIN_SCORE    (WIN),
        .p_PAUSE_CYCLES (PAUSE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sk        (sk_if.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        string      name;
        logic       start;
        logic       m1;
        logic       m2;
        logic [EW-1:0] exp;
    } vec_t;

    vec_t          vecs[$];
    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_bad = 0;

    // {p1, p2, play, serve_dir, game_over, winner, state}
    function automatic logic [EW-1:0] pack_exp(input int p1, input int p2,
                                               input logic play, input logic sd,
                                               input logic go, input logic [1:0] win,
                                               input logic [1:0] st);
        return {4'(p1), 4'(p2), play, sd, go, win, st};
    endfunction

    function automatic logic [EW-1:0] actual();
        return {sk_if.score_p1, sk_if.score_p2, sk_if.play, sk_if.serve_dir,
                sk_if.game_over, sk_if.winner, 2'(dbg_state)};
    endfunction

    task automatic add(input string name, input logic s, input logic m1, input logic m2,
                       input int p1, input int p2, input logic play, input logic sd,
                       input logic go, input logic [1:0] win, input logic [1:0] st);
        vec_t v;
        v.name  = name;
        v.start = s;
        v.m1    = m1;
        v.m2    = m2;
        v.exp   = pack_exp(p1, p2, play, sd, go, win, st);
        vecs.push_back(v);
    endtask

    // PAUSE-1 further frozen cycles, then the cycle that resumes play.
    task automatic add_pause(input string name, input int p1, input int p2, input logic sd);
        for (int i = 0; i < PAUSE - 1; i++)
            add(name, 0, 0, 0, p1, p2, 0, sd, 0, WIN_NONE, ST_PAUSE);
        add({name, "_resume"}, 0, 0, 0, p1, p2, 1, sd, 0, WIN_NONE, ST_PLAY);
    endtask

    task automatic check(input string name);
        logic [EW-1:0] exp;
        logic [EW-1:0] act;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, actual=%h", name, actual());
            return;
        end
        exp = exp_q.pop_front();
        act = actual();
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual p1=%0d p2=%0d play=%b srv=%b go=%b win=%b st=%0d required p1=%0d p2=%0d play=%b srv=%b go=%b win=%b st=%0d",
                     name, act[14:11], act[10:7], act[6], act[5], act[4], act[3:2], act[1:0],
                     exp[14:11], exp[10:7], exp[6], exp[5], exp[4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        sk_if.start   = v.start;
        sk_if.miss_p1 = v.m1;
        sk_if.miss_p2 = v.m2;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        sk_if.start   = 1'b0;
        sk_if.miss_p1 = 1'b0;
        sk_if.miss_p2 = 1'b0;
        check(v.name);
    endtask

    task automatic step(input string name, input logic s, input logic m1, input logic m2,
                        input int p1, input int p2, input logic play, input logic sd,
                        input logic go, input logic [1:0] win, input logic [1:0] st);
        vec_t v;
        v.name  = name;
        v.start = s;
        v.m1    = m1;
        v.m2    = m2;
        v.exp   = pack_exp(p1, p2, play, sd, go, win, st);
        drive(v);
    endtask

    // ---------------- test ----------------
    initial begin
        sk_if.start   = 1'b0;
        sk_if.miss_p1 = 1'b0;
        sk_if.miss_p2 = 1'b0;

        // Vector table: inputs for one edge and the outputs right after it.
        add("idle_nop",      0, 0, 0, 0, 0, 0, 0, 0, WIN_NONE, ST_IDLE);
        add("idle_miss",     0, 1, 0, 0, 0, 0, 0, 0, WIN_NONE, ST_IDLE);
        add("start",         1, 0, 0, 0, 0, 1, 0, 0, WIN_NONE, ST_PLAY);
        add("miss_p2",       0, 0, 1, 1, 0, 0, 1, 0, WIN_NONE, ST_PAUSE);
        add_pause("pause1",  1, 0, 1);
        add("both_miss",     0, 1, 1, 1, 0, 0, 0, 0, WIN_NONE, ST_PAUSE);
        add_pause("pause2",  1, 0, 0);
        add("miss_p1",       0, 1, 0, 1, 1, 0, 0, 0, WIN_NONE, ST_PAUSE);
        add("pause_miss_p1", 0, 1, 0, 1, 1, 0, 0, 0, WIN_NONE, ST_PAUSE);
        add("pause_start",   1, 0, 0, 1, 1, 0, 0, 0, WIN_NONE, ST_PAUSE);
        add("pause_both",    0, 1, 1, 1, 1, 0, 0, 0, WIN_NONE, ST_PAUSE);
        add("pause3_resume", 0, 0, 0, 1, 1, 1, 0, 0, WIN_NONE, ST_PLAY);
        add("play_start",    1, 0, 0, 1, 1, 1, 0, 0, WIN_NONE, ST_PLAY);
        add("p2_to_2",       0, 1, 0, 1, 2, 0, 0, 0, WIN_NONE, ST_PAUSE);
        add_pause("pause4",  1, 2, 0);
        add("p2_wins",       0, 1, 0, 1, 3, 0, 0, 1, WIN_P2, ST_GAME_OVER);
        add("go_miss_p1",    0, 1, 0, 1, 3, 0, 0, 1, WIN_P2, ST_GAME_OVER);
        add("go_miss_p2",    0, 0, 1, 1, 3, 0, 0, 1, WIN_P2, ST_GAME_OVER);
        add("go_hold",       0, 0, 0, 1, 3, 0, 0, 1, WIN_P2, ST_GAME_OVER);
        add("restart1",      1, 0, 0, 0, 0, 1, 0, 0, WIN_NONE, ST_PLAY);
        add("p1_to_1",       0, 0, 1, 1, 0, 0, 1, 0, WIN_NONE, ST_PAUSE);
        add_pause("pause5",  1, 0, 1);
        add("p1_to_2",       0, 0, 1, 2, 0, 0, 1, 0, WIN_NONE, ST_PAUSE);
        add_pause("pause6",  2, 0, 1);
        add("p1_wins",       0, 0, 1, 3, 0, 0, 1, 1, WIN_P1, ST_GAME_OVER);
        add("restart2",      1, 0, 0, 0, 0, 1, 1, 0, WIN_NONE, ST_PLAY);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(pack_exp(0, 0, 0, 0, 0, WIN_NONE, ST_IDLE));
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) drive(vecs[i]);

        // Asynchronous reset in the middle of a pause, between clock edges.
        step("pre_reset_miss", 0, 0, 1, 1, 0, 0, 1, 0, WIN_NONE, ST_PAUSE);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(pack_exp(0, 0, 0, 0, 0, WIN_NONE, ST_IDLE));
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_idle",  0, 0, 1, 0, 0, 0, 0, 0, WIN_NONE, ST_IDLE);
        step("post_reset_start", 1, 0, 0, 0, 0, 1, 0, 0, WIN_NONE, ST_PLAY);

        // Random pulses while paused must never score or cut the pause short.
        step("rnd_enter", 0, 1, 0, 0, 1, 0, 0, 0, WIN_NONE, ST_PAUSE);
        for (int i = 0; i < PAUSE - 1; i++)
            step("rnd_pause", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 0, 1, 0, 0, 0, WIN_NONE, ST_PAUSE);
        step("rnd_resume", 0, 0, 0, 0, 1, 1, 0, 0, WIN_NONE, ST_PLAY);

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
